// File: rtl/fx_pkg.sv
// Fixed-point divide support: widths, saturation limits, FSM states,
// and sign/magnitude helpers shared by the divider datapath.
package fx_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_FRAC_BITS = 32;
  localparam int DEF_N         = DEF_WIDTH + DEF_FRAC_BITS;

  typedef logic signed [DEF_WIDTH-1:0] fx_t;

  localparam fx_t FX_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam fx_t FX_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  // Largest magnitudes representable for each result sign.
  localparam logic [DEF_N-1:0] POS_LIM =
    {{(DEF_N-DEF_WIDTH+1){1'b0}}, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_N-1:0] NEG_LIM =
    {{DEF_FRAC_BITS{1'b0}}, 1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  typedef struct packed {
    fx_t  q;
    logic ovf;
  } fx_res_t;

  // Unsigned magnitude; the most negative value maps to 2^(W-1).
  function automatic logic [DEF_WIDTH-1:0] fx_abs(input fx_t a);
    logic [DEF_WIDTH-1:0] m;
    m = a;
    if (a[DEF_WIDTH-1])
      m = ~m + 1'b1;
    return m;
  endfunction

  // Apply the sign to a quotient magnitude, saturating on overflow.
  function automatic fx_res_t fx_sat_neg(
    input logic             neg,
    input logic [DEF_N-1:0] mag
  );
    fx_res_t r;
    r.q   = '0;
    r.ovf = 1'b0;
    if (!neg) begin
      if (mag > POS_LIM) begin
        r.q   = FX_MAX;
        r.ovf = 1'b1;
      end else begin
        r.q = mag[DEF_WIDTH-1:0];
      end
    end else begin
      if (mag > NEG_LIM) begin
        r.q   = FX_MIN;
        r.ovf = 1'b1;
      end else begin
        r.q = ~mag[DEF_WIDTH-1:0] + 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fx_divide_seq.sv
// Sequential signed fixed-point divider, q = (a <<< FRAC_BITS) / b,
// one restoring step per cycle, valid/ready on both sides.
// Ports: clk_in, rst_in (sync, active high); a_in, b_in, valid_in,
// ready_out (operand side); q_out, div_zero_out, ovf_out, valid_out,
// ready_in (result side).
module fx_divide_seq
  import fx_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] b_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic signed [WIDTH-1:0] q_out,
  output logic                    div_zero_out,
  output logic                    ovf_out,
  output logic                    valid_out,
  input  logic                    ready_in
);

  localparam int N  = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N + 1);

  div_state_t state, state_n;

  logic                    sign_q, sign_n;
  logic [WIDTH-1:0]        bmag, bmag_n;
  logic [N-1:0]            num, num_n;
  logic [WIDTH:0]          rem, rem_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic signed [WIDTH-1:0] q_n;
  logic                    dz_n, ovf_n;

  logic [WIDTH:0]          rem_sh;
  logic [WIDTH:0]          diff;
  logic                    take;
  logic [N-1:0]            num_step;
  fx_res_t                 res;

  always_comb begin
    // num doubles as the quotient: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    rem_sh   = {rem[WIDTH-1:0], num[N-1]};
    diff     = rem_sh - {1'b0, bmag};
    take     = rem[WIDTH] | (rem_sh >= {1'b0, bmag});
    num_step = {num[N-2:0], take};
    res      = fx_sat_neg(sign_q, num_step);

    state_n   = state;
    sign_n    = sign_q;
    bmag_n    = bmag;
    num_n     = num;
    rem_n     = rem;
    cnt_n     = cnt;
    q_n       = q_out;
    dz_n      = div_zero_out;
    ovf_n     = ovf_out;
    ready_out = (state == IDLE);
    valid_out = (state == DONE);

    unique case (state)
      IDLE: begin
        if (valid_in) begin
          sign_n = a_in[WIDTH-1] ^ b_in[WIDTH-1];
          bmag_n = fx_abs(b_in);
          num_n  = {fx_abs(a_in), {FRAC_BITS{1'b0}}};
          rem_n  = '0;
          cnt_n  = CW'(N);
          ovf_n  = 1'b0;
          if (b_in == '0) begin
            q_n     = a_in[WIDTH-1] ? FX_MIN : FX_MAX;
            dz_n    = 1'b1;
            state_n = DONE;
          end else begin
            dz_n    = 1'b0;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        rem_n = take ? diff : rem_sh;
        num_n = num_step;
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          q_n     = res.q;
          ovf_n   = res.ovf;
          state_n = DONE;
        end
      end
      DONE: begin
        if (ready_in)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      sign_q       <= 1'b0;
      bmag         <= '0;
      num          <= '0;
      rem          <= '0;
      cnt          <= '0;
      q_out        <= '0;
      div_zero_out <= 1'b0;
      ovf_out      <= 1'b0;
    end else begin
      state        <= state_n;
      sign_q       <= sign_n;
      bmag         <= bmag_n;
      num          <= num_n;
      rem          <= rem_n;
      cnt          <= cnt_n;
      q_out        <= q_n;
      div_zero_out <= dz_n;
      ovf_out      <= ovf_n;
    end
  end

endmodule

// File: tb/tb_fx_divide_seq.sv
// Directed-vector bench for fx_divide_seq (32.32 fixed point).
// Each test task drives its scenario and checks results inline.
module tb_fx_divide_seq;

  logic               clk;
  logic               rst_in;
  logic signed [31:0] a_in;
  logic signed [31:0] b_in;
  logic               valid_in;
  logic               ready_out;
  logic signed [31:0] q_out;
  logic               div_zero_out;
  logic               ovf_out;
  logic               valid_out;
  logic               ready_in;

  int tests_run    = 0;
  int tests_failed = 0;

  fx_divide_seq dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .a_in        (a_in),
    .b_in        (b_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .q_out       (q_out),
    .div_zero_out(div_zero_out),
    .ovf_out     (ovf_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!ready_out && guard < 200) begin
      tick();
      guard++;
    end
    if (!ready_out) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_ready: ready_out=%0b required 1", ready_out);
    end
    a_in     = a;
    b_in     = b;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  // lat = cycles from the accept edge to the first cycle with valid_out
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_out && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out();
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in   = 1'b1;
    valid_in = 1'b1;
    a_in     = 32'h0000_0005;
    b_in     = 32'h0000_0000;
    repeat (3) tick();
    rst_in   = 1'b0;
    valid_in = 1'b0;
    tests_run++;
    if (ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset ready_out: got %0b want 1", ready_out);
    end
    tests_run++;
    if (valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset valid_out: got %0b want 0", valid_out);
    end
    tests_run++;
    if (q_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset q_out: got %h want 0", q_out);
    end
    tests_run++;
    if ({div_zero_out, ovf_out} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset flags: got dz=%0b ovf=%0b want 0 0",
               div_zero_out, ovf_out);
    end
  endtask

  task automatic test_divide();
    logic [31:0] va [12] = '{
      32'h1000_0000, 32'hF000_0000, 32'hE000_0000, 32'h0000_0001,
      32'hFFFF_FFFF, 32'h2000_0000, 32'h0000_0000, 32'h8000_0000,
      32'hC000_0000, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] vb [12] = '{
      32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h0000_0003,
      32'h0000_0003, 32'h4000_0000, 32'hFFFF_FFFB, 32'h8000_0000,
      32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    logic [31:0] vq [12] = '{
      32'h4000_0000, 32'hC000_0000, 32'h8000_0000, 32'h5555_5555,
      32'hAAAA_AAAB, 32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF,
      32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic vdz  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic vovf [12] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0};
    int   vlat [12] = '{65, 65, 65, 65, 65, 65, 65, 65, 65, 1, 1, 1};
    int   lat;
    for (int i = 0; i < 12; i++) begin
      send(va[i], vb[i]);
      wait_valid(lat);
      tests_run++;
      if (lat != vlat[i]) begin
        tests_failed++;
        $display("FAIL div%0d latency: got %0d want %0d", i, lat, vlat[i]);
      end
      tests_run++;
      if (q_out !== vq[i]) begin
        tests_failed++;
        $display("FAIL div%0d q: got %h want %h", i, q_out, vq[i]);
      end
      tests_run++;
      if (div_zero_out !== vdz[i]) begin
        tests_failed++;
        $display("FAIL div%0d div_zero: got %0b want %0b",
                 i, div_zero_out, vdz[i]);
      end
      tests_run++;
      if (ovf_out !== vovf[i]) begin
        tests_failed++;
        $display("FAIL div%0d ovf: got %0b want %0b", i, ovf_out, vovf[i]);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(32'h0000_0001, 32'h0000_0003);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      a_in     = 32'h1000_0000 + i;
      b_in     = (i % 2 == 0) ? 32'h0 : 32'h4000_0000;
      valid_in = 1'b1;
      tick();
      tests_run++;
      if (q_out !== 32'h5555_5555 || valid_out !== 1'b1 ||
          ready_out !== 1'b0 || ovf_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold%0d: got q=%h v=%0b r=%0b ovf=%0b want 55555555 1 0 0",
                 i, q_out, valid_out, ready_out, ovf_out);
      end
    end
    valid_in = 1'b0;
    release_out();
    tests_run++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL after_handshake: got v=%0b r=%0b want 0 1",
               valid_out, ready_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ba [3] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] bb [3] = '{32'h0000_0004, 32'h0000_0008, 32'hFFFF_FFFD};
    logic [31:0] bq [3] = '{32'h4000_0000, 32'hC000_0000, 32'h5555_5555};
    int lat;
    for (int i = 0; i < 3; i++) begin
      // the accept lands on the cycle right after the previous handshake
      a_in     = ba[i];
      b_in     = bb[i];
      valid_in = 1'b1;
      tests_run++;
      if (ready_out !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b%0d ready: got %0b want 1", i, ready_out);
      end
      tick();
      valid_in = 1'b0;
      wait_valid(lat);
      tests_run++;
      if (lat != 65 || q_out !== bq[i] || ovf_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b%0d: got lat=%0d q=%h ovf=%0b want 65 %h 0",
                 i, lat, q_out, ovf_out, bq[i]);
      end
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    send(32'h1000_0000, 32'h4000_0000);
    repeat (29) tick();
    tests_run++;
    if (ready_out !== 1'b0 || valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_busy: got r=%0b v=%0b want 0 0", ready_out, valid_out);
    end
    rst_in   = 1'b1;
    valid_in = 1'b1;
    a_in     = 32'h0000_0005;
    b_in     = 32'h0000_0000;
    tick();
    rst_in   = 1'b0;
    valid_in = 1'b0;
    tests_run++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1 || q_out !== 32'h0 ||
        div_zero_out !== 1'b0 || ovf_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got v=%0b r=%0b q=%h dz=%0b ovf=%0b want 0 1 0 0 0",
               valid_out, ready_out, q_out, div_zero_out, ovf_out);
    end
    seen = 1'b0;
    repeat (70) begin
      tick();
      if (valid_out) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL aborted_output: got valid_out seen=%0b want 0", seen);
    end
    send(32'hF000_0000, 32'h4000_0000);
    wait_valid(lat);
    tests_run++;
    if (lat != 65 || q_out !== 32'hC000_0000 || ovf_out !== 1'b0 ||
        div_zero_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_op: got lat=%0d q=%h ovf=%0b dz=%0b want 65 c0000000 0 0",
               lat, q_out, ovf_out, div_zero_out);
    end
    release_out();
  endtask

  initial begin
    rst_in   = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    test_reset();
    test_divide();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
